// File: rtl/oc_tick_scheduler_if.sv
// Config handshake and per-slot status bundle for oc_tick_scheduler.
// The scheduler sits on the slave modport and the requester on the master.
interface oc_tick_scheduler_if #(
    parameter int Slots      = 4,
    parameter int CountWidth = 16
);
    localparam int SlotWidth = (Slots > 1) ? $clog2(Slots) : 1;

    logic                  cfgValid;
    logic                  cfgReady;
    logic [SlotWidth-1:0]  cfgSlot;
    logic                  cfgStart;
    logic [1:0]            cfgUnit;
    logic                  cfgPeriodic;
    logic [CountWidth-1:0] cfgPeriod;
    logic [Slots-1:0]      active;
    logic [Slots-1:0]      fire;

    modport master (
        output cfgValid, cfgSlot, cfgStart, cfgUnit, cfgPeriodic, cfgPeriod,
        input  cfgReady, active, fire
    );

    modport slave (
        input  cfgValid, cfgSlot, cfgStart, cfgUnit, cfgPeriodic, cfgPeriod,
        output cfgReady, active, fire
    );
endinterface

// File: rtl/oc_tick_scheduler.sv
// Multi-slot timer scheduler: one shared decrement engine swept across all
// slots on every us/ms/s tick edge from the chip status bus.
package oclib_pkg;
    typedef struct packed {
        logic tick1us;
        logic tick1ms;
        logic tick1s;
        logic halt;
        logic clear;
    } chip_status_s;
endpackage

module oclib_synchronizer #(
    parameter int Width  = 1,
    parameter int Stages = 2
) (
    input  logic             clock,
    input  logic [Width-1:0] dataIn,
    output logic [Width-1:0] dataOut
);
    logic [Width-1:0] stage [Stages];

    always_ff @(posedge clock) begin
        stage[0] <= dataIn;
        for (int i = 1; i < Stages; i++) stage[i] <= stage[i-1];
    end

    assign dataOut = stage[Stages-1];
endmodule

// state | meaning
// IDLE  | waiting for a tick edge; config port open
// SWEEP | visiting slot idx this cycle; config port closed
module oc_tick_scheduler #(
    parameter int ClockHz    = 100_000_000,
    parameter int Slots      = 4,
    parameter int CountWidth = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  oclib_pkg::chip_status_s  chipStatus,
    oc_tick_scheduler_if.slave       cfgBus
);
    localparam int SlotWidth = (Slots > 1) ? $clog2(Slots) : 1;

    if (Slots < 1 || Slots > 16) begin : gBadSlots
        $error("oc_tick_scheduler: Slots must be 1..16");
    end
    if (Slots + 2 > ClockHz / 1_000_000) begin : gBadClock
        $error("oc_tick_scheduler: a sweep cannot finish between us ticks");
    end

    typedef enum logic {IDLE, SWEEP} state_e;

    logic                  rstSync;
    state_e                state, stateN;
    logic [SlotWidth-1:0]  idx, idxN;
    logic [2:0]            snap, snapN, pending, pendingN;
    logic [2:0]            tickQ, tickNow, edgesEff;
    logic                  visit, visitHit, accept;
    logic [CountWidth-1:0] periodEff;
    logic [1:0]            unitEff;

    logic [CountWidth-1:0] count  [Slots];
    logic [CountWidth-1:0] reload [Slots];
    logic [1:0]            slotUnit [Slots];
    logic [Slots-1:0]      periodic, activeQ, fireQ;

    oclib_synchronizer #(.Width(1), .Stages(2)) uResetSync (
        .clock   (clock),
        .dataIn  (reset),
        .dataOut (rstSync)
    );

    // bit 0 = us, 1 = ms, 2 = s; halted or cleared edges are dropped outright
    assign tickNow  = {chipStatus.tick1s, chipStatus.tick1ms, chipStatus.tick1us};
    assign edgesEff = (chipStatus.halt || chipStatus.clear) ? 3'b000 : (tickNow & ~tickQ);

    always_ff @(posedge clock) begin
        if (rstSync) begin
            state   <= IDLE;
            idx     <= '0;
            snap    <= '0;
            pending <= '0;
            tickQ   <= '0;
        end else begin
            state   <= stateN;
            idx     <= idxN;
            snap    <= snapN;
            pending <= pendingN;
            tickQ   <= tickNow;
        end
    end

    always_comb begin
        stateN   = state;
        idxN     = idx;
        snapN    = snap;
        pendingN = pending;
        visit    = 1'b0;
        case (state)
            IDLE: begin
                if (edgesEff != 3'b000) begin
                    stateN   = SWEEP;
                    idxN     = '0;
                    snapN    = edgesEff | pending;
                    pendingN = '0;
                end
            end
            SWEEP: begin
                visit    = 1'b1;
                pendingN = pending | edgesEff;
                if (idx == SlotWidth'(Slots - 1)) begin
                    idxN = '0;
                    if (pendingN != 3'b000) begin
                        snapN    = pendingN;
                        pendingN = '0;
                    end else begin
                        stateN = IDLE;
                    end
                end else begin
                    idxN = SlotWidth'(idx + 1'b1);
                end
            end
            default: stateN = IDLE;
        endcase
        if (chipStatus.clear) begin
            stateN   = IDLE;
            idxN     = '0;
            pendingN = '0;
            visit    = 1'b0;
        end
    end

    assign cfgBus.cfgReady = (state == IDLE);
    assign accept    = cfgBus.cfgValid && cfgBus.cfgReady && !chipStatus.clear
                       && (int'(cfgBus.cfgSlot) < Slots);
    assign periodEff = (cfgBus.cfgPeriod == '0) ? CountWidth'(1) : cfgBus.cfgPeriod;
    assign unitEff   = (cfgBus.cfgUnit == 2'd3) ? 2'd2 : cfgBus.cfgUnit;
    assign visitHit  = visit && activeQ[idx] && snap[slotUnit[idx]];

    // config only lands in IDLE and visits only in SWEEP, so they never collide
    always_ff @(posedge clock) begin
        if (rstSync) begin
            activeQ  <= '0;
            fireQ    <= '0;
            periodic <= '0;
            for (int i = 0; i < Slots; i++) begin
                count[i]    <= '0;
                reload[i]   <= '0;
                slotUnit[i] <= '0;
            end
        end else begin
            fireQ <= '0;
            if (chipStatus.clear) begin
                activeQ <= '0;
            end else begin
                if (accept) begin
                    if (cfgBus.cfgStart) begin
                        activeQ[cfgBus.cfgSlot]  <= 1'b1;
                        count[cfgBus.cfgSlot]    <= periodEff;
                        reload[cfgBus.cfgSlot]   <= periodEff;
                        slotUnit[cfgBus.cfgSlot] <= unitEff;
                        periodic[cfgBus.cfgSlot] <= cfgBus.cfgPeriodic;
                    end else begin
                        activeQ[cfgBus.cfgSlot] <= 1'b0;
                    end
                end
                if (visitHit) begin
                    if (count[idx] == CountWidth'(1)) begin
                        fireQ[idx] <= 1'b1;
                        if (periodic[idx]) count[idx] <= reload[idx];
                        else               activeQ[idx] <= 1'b0;
                    end else begin
                        count[idx] <= count[idx] - CountWidth'(1);
                    end
                end
            end
        end
    end

    assign cfgBus.active = activeQ;
    assign cfgBus.fire   = fireQ;
endmodule

// File: doc/oc_tick_scheduler.md
# oc_tick_scheduler

Multi-slot software-visible timer scheduler built on the chip-wide real-time ticks carried in `oclib_pkg::chip_status_s`. It owns one shared decrement engine and time-shares it across `Slots` timer slots. Requesters program slots through a single valid/ready config port. Each slot counts microsecond, millisecond or second ticks and emits a one-cycle `fire` pulse on expiry. The block sits beside the chip status generator and serves CSR-driven timeouts, watchdogs and periodic housekeeping.

## Interface
- `ClockHz`, 100_000_000, clock frequency; used only for the elaboration check.
- `Slots`, 4, number of timer slots, 1..16.
- `CountWidth`, 16, width of the per-slot period/count.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high; internally passed through `oclib_synchronizer` before use.
- `chipStatus` in `oclib_pkg::chip_status_s`: source of `tick1us`, `tick1ms`, `tick1s`, `halt`, `clear`.
- `cfgValid` in 1: config request.
- `cfgReady` out 1: config accepted when `cfgValid && cfgReady`.
- `cfgSlot` in $clog2(Slots) (min 1): target slot; values >= Slots are accepted and ignored.
- `cfgStart` in 1: 1 = start/restart slot, 0 = stop slot.
- `cfgUnit` in 2: 0 = us, 1 = ms, 2 = s, 3 = reserved (treated as s).
- `cfgPeriodic` in 1: 1 = reload on expiry, 0 = one-shot.
- `cfgPeriod` in CountWidth: ticks to expiry; 0 is treated as 1.
- `active` out Slots: per-slot running flag.
- `fire` out Slots: per-slot one-cycle expiry pulse.

## Operation
- Tick inputs are multi-cycle stretched pulses (about 5 cycles). Each of the three is rising-edge detected against a registered copy. Only the edge counts.
- Per-slot state: `active`, `periodic`, `unit`, `reload`, `count`.
- FSM states are IDLE and SWEEP, with sweep index `idx`.
- IDLE:
  - `cfgReady` = 1.
  - Any tick edge in the cycle moves the FSM to SWEEP with `idx`=0. The 3-bit unit snapshot loads with (edges | pending) and pending clears.
- SWEEP:
  - `cfgReady` = 0.
  - Exactly one slot is visited per cycle, `idx` = 0..Slots-1.
  - Tick edges arriving during SWEEP OR into `pending` for the next sweep.
  - After the visit to `idx`=Slots-1: if pending != 0, go to SWEEP `idx`=0 with snapshot = pending; else go to IDLE.
- Slot visit (`active` and snapshot[unit] set):
  - If `count` == 1, the slot expires: `fire[idx]` is asserted the next cycle. If `periodic`, `count`<=`reload`; else `active`<=0.
  - Otherwise, `count`<=`count`-1.
- Config accept, start: `active`=1, `count`=`reload`=max(`cfgPeriod`,1), and `unit`/`periodic` are latched. Restarting a running slot discards its old count and does not fire.
- Config accept, stop: `active`=0 and no fire.
- `chipStatus.halt`: while high, tick edges are discarded (not recorded, no sweep started). A sweep already in progress completes.
- `chipStatus.clear`: when high, every `active` goes to 0 and pending clears. A visit in that cycle produces no fire. `clear` has priority over config.
- Elaboration `$error` if Slots+2 > ClockHz/1_000_000; this guarantees a sweep finishes between us edges.

## Timing
- Reset values:
  - `active`=0, `fire`=0, `cfgReady`=1 (first cycle after the synchronized reset deasserts).
  - State IDLE, pending=0, all slot counts 0.
  - Registered tick copies reset to 0, so a tick already high at reset exit counts as an edge.
- The us/ms/s edges are aligned: a ms boundary gives both us and ms in one snapshot, handled in a single sweep.
- Latency: tick edge in IDLE at cycle t → slot i visited at t+1+i → `fire[i]` high at t+2+i, for exactly one cycle.
- A config accepted in the same cycle as a tick edge takes effect first. That slot is then decremented by the sweep at t+1, so period P fires after P-1 further ticks.
- `fire` and `active` are registered outputs. On one-shot expiry, `active` falls in the same cycle `fire` rises.

## Test plan
- Slot 0 starts one-shot, us, P=3. Three us edges → `fire[0]` exactly once, 2 cycles after the 3rd edge at idx 0; `active[0]` then 0.
- Slot 2 starts periodic, ms, P=2, sharing us traffic with slot 1 (us, P=5). Over 10 ms → 5 `fire[2]` pulses spaced 2 ms apart, each at edge+4 cycles; slot 1 fires at the expected us counts.
- cfgValid is held through a sweep → `cfgReady` stays 0 for Slots cycles, then the handshake completes; stop on a running slot → no fire, `active` 0.
- `halt` is high across 3 us edges with slot 0 at count 2 → no decrement; after `halt` drops, 2 more edges → fire.
- `clear` is pulsed with all slots active and pending set → all `active` 0, no `fire`, FSM returns to IDLE.
- `cfgPeriod`=0 → behaves as P=1; `cfgSlot`=Slots → handshake completes and no state changes.
